nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands using one external 4-bit ripple carry adder, one nibble per clock, LSB nibble first.
- Upstream: it drives the adder's nibble operands and carry-in from latched operand registers.
- Downstream: it captures the adder's sum nibble and carry-out, chaining the carry through a register.
- Sits between a valid/ready operand source and a valid/ready result sink.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4. NIB = WIDTH/4 adder passes per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand source has a request.
- in_ready  output  1  block can accept a request; equals (state==IDLE).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in of the whole addition.
- add_a  output  4  nibble of A presented to the adder.
- add_b  output  4  nibble of B presented to the adder.
- add_cin  output  1  carry presented to the adder.
- add_sum  input  4  adder sum nibble, combinational from add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out, combinational.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts the result.
- out_sum  output  WIDTH  result sum.
- out_cout  output  1  final carry-out.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous):
  - state=IDLE; operand regs, sum reg, carry reg and nibble index all 0.
  - out_valid=0, out_sum=0, out_cout=0, add_a/add_b/add_cin=0.
  - Reset takes effect immediately, including mid-RUN or in DONE; any operation in flight is discarded with no out_valid.
  - in_valid is ignored while rst_n is low.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_a, in_b; carry reg <= in_cin; idx <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - add_a = A[4*idx+3:4*idx], add_b = B[4*idx+3:4*idx], add_cin = carry reg.
  - Each edge: sum reg nibble idx <= add_sum; carry reg <= add_cout; idx <= idx+1.
  - On the edge where idx==NIB-1: go to DONE instead of incrementing.
  - Index register width is max(1, clog2(NIB)); it never wraps past NIB-1.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- DONE:
  - out_valid=1; out_sum = sum reg; out_cout = carry reg. Both held stable until the handshake.
  - in_ready=0; in_valid is ignored.
  - On an edge with out_ready=1: go to IDLE. out_sum and out_cout keep their value until overwritten by the next operation.
- Latency:
  - The accept edge is T. out_valid is high in the cycle after edge T+NIB.
  - Minimum spacing between accepts is NIB+2 cycles (IDLE, NIB×RUN, DONE).
- out_sum during RUN:
  - Nibbles update progressively from the LSB nibble up.
  - Consumers must qualify out_sum with out_valid. The bench checks out_sum only in DONE.
- Arithmetic:
  - {out_cout, out_sum} = in_a + in_b + in_cin, exact, modulo 2^(WIDTH+1).
  - The block assumes the adder is purely combinational with no registered stage.
- No simultaneous accept and complete: a new request can only be taken in IDLE.

Test Plan:
1. Reset: hold rst_n=0 with random inputs. Required: out_valid=0, out_sum=0, out_cout=0, add_*=0. After release, in_ready=1. Assert rst_n mid-cycle and check clear without a clock edge.
2. WIDTH=16, a=0x1234, b=0x4321, cin=0. Required: add_a sequence 4,3,2,1; add_b sequence 1,2,3,4; out_sum=0x5555, out_cout=0; out_valid exactly 4 edges after the accept edge.
3. Full carry ripple, a=0xFFFF, b=0x0000, cin=1. Required: add_cin sequence 1,1,1,1; out_sum=0x0000, out_cout=1.
4. Backpressure: a=0x8000, b=0x8000, cin=0, hold out_ready=0 for 5 cycles while pulsing in_valid. Required: out_valid=1, out_sum=0x0000 and out_cout=1 stable throughout; in_ready=0; pulses ignored. After one out_ready=1 edge: IDLE, and the next op (0x0001+0x0001 → 0x0002) completes correctly.
5. Reset mid-operation: start 0xAAAA+0x5555, assert rst_n=0 after 2 RUN edges. Required: state IDLE, all outputs 0, no out_valid ever. After release, 0x00FF+0x0001, cin=0 → out_sum=0x0100, out_cout=0.
6. WIDTH=4, a=0xF, b=0x1, cin=0. Required: out_sum=0x0, out_cout=1, out_valid one edge after accept. Also run random back-to-back ops against a reference sum for WIDTH=4, 8 and 16.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a WIDTH-bit addition through one external 4-bit combinational adder,
// one nibble per clock, LSB nibble first, between valid/ready source and sink.
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NIB-1:0][3:0]    a_q, a_d;
    logic [NIB-1:0][3:0]    b_q, b_d;
    logic [NIB-1:0][3:0]    sum_q, sum_d;
    logic                   carry_q, carry_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state, nibble select and adder drive
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        in_ready = 1'b0;
        add_a    = 4'h0;
        add_b    = 4'h0;
        add_cin  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Loop-based select keeps the index width legal when NIB is 1
                for (int unsigned n = 0; n < NIB; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        add_a    = a_q[n];
                        add_b    = b_q[n];
                        sum_d[n] = add_sum;
                    end
                end
                add_cin = carry_q;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result held in the sum/carry registers until the next operation overwrites it
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

endmodule
